ps2_scancode_history: RTL and testbench
=======================================

Name: ps2_scancode_history

Overview:
- Parametrised successor to the team's PS/2 keyboard-to-hex path.
- Receives PS/2 frames fully synchronously to the system clock, checks framing, odd parity and timeout, and decodes the E0 (extended) and F0 (break) prefixes.
- Keeps a shift history of the last DEPTH bytes and drives 2*DEPTH hex digits through the team's hex_decoder.
- Sits between the board PS2_CLK/PS2_DAT pins and the HEX displays or game logic.

Parameters:
- DEPTH, 2, number of history bytes kept and displayed (>=1).
- TIMEOUT_CYCLES, 50000, clocks allowed between PS/2 falling edges inside a frame before abort.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_clock  in  1  raw PS/2 clock line, asynchronous.
- ps2_data  in  1  raw PS/2 data line, asynchronous.
- code_out  out  8  last accepted byte.
- code_valid  out  1  one-cycle pulse per accepted byte.
- key_valid  out  1  one-cycle pulse per non-prefix byte, i.e. a complete key event.
- code_ext  out  1  E0 seen before the current key event; valid with key_valid.
- code_break  out  1  F0 seen before the current key event; valid with key_valid.
- frame_error  out  1  one-cycle pulse on a parity, stop-bit or timeout error.
- history  out  8*DEPTH  byte history; [7:0] is the newest entry.
- segments  out  14*DEPTH  7-bit segment fields. Digit 2i is the low nibble of history entry i, digit 2i+1 the high nibble. Encoding is that of hex_decoder.

Behaviour:
- Interface: one clock, `clock`. `reset` is synchronous and active-high.
- Reset values: all outputs 0; history 0, so segments show "0"; FSM in IDLE; prefix flags clear; synchroniser flops 1.
- Input sync: ps2_clock and ps2_data each pass through 2 flops. A bit event is synced clock 1 in the previous cycle and 0 in the current cycle. Data is sampled from the synced data line in that same cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an event with data=0, go to DATA and set bit_cnt=0. On an event with data=1, stay in IDLE, no error.
  - DATA: shift in LSB first. After the 8th bit, go to PARITY.
  - PARITY: latch the bit, go to STOP.
  - STOP: on the event, return to IDLE. Accept if stop=1 and the XOR of 8 data bits plus parity is 1. Otherwise pulse frame_error.
- Latency: code_out updates and code_valid pulses in the cycle after the stop-bit event is detected.
- Timeout: idle counter clears on every event and counts only outside IDLE. When it reaches TIMEOUT_CYCLES, go to IDLE, pulse frame_error and discard the partial byte.
- Prefix decode, on each accepted byte:
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - Any other byte pulses key_valid with code_ext=ext_pend and code_break=brk_pend, then clears both. code_ext and code_break hold until the next key event.
  - Prefix bytes pulse code_valid but not key_valid.
- History: on each history push, history <= {history[8*DEPTH-9:0], byte}. The oldest entry drops off. For DEPTH=1, history = byte.
- Simultaneous events:
  - Timeout and a bit event in the same cycle: the event wins and the counter clears.
  - Reset dominates everything.
- Reset mid-frame: the frame is discarded and no pulses are produced. The next full frame after reset is received normally.
- segments is purely combinational from history.

Optional Feature:
- Macro: PS2_BREAK_FILTER_EN.
- Defined: history pushes only on key_valid with code_break=0 (key presses). Prefix bytes and released keys are not recorded. code_out, code_valid and the flags are unchanged.
- Undefined: history pushes on every code_valid, i.e. raw byte stream.

Test Plan:
- Reset, DEPTH=2, then frame 0x1C with parity bit 0 and stop 1 -> one code_valid and one key_valid; code_out=0x1C; code_ext=0, code_break=0; history=16'h001C; frame_error never pulses.
- Frames F0 then 1C -> code_valid x2, key_valid x1 with code_break=1.
  - Macro undefined: history=16'hF01C.
  - Macro defined: history unchanged from its prior value.
- Frames E0, 75 -> key_valid with code_ext=1, code_break=0, code_out=0x75. The next plain 0x29 gives code_ext=0.
- Frame 0x1C with parity bit 1 -> frame_error pulse, no code_valid, history unchanged. Stop bit 0 on a valid byte -> same result.
- Start bit plus 4 data bits, then ps2_clock held high for TIMEOUT_CYCLES clocks -> frame_error pulse, FSM in IDLE. A following complete frame 0x29 is accepted with code_out=0x29.
- Reset asserted for 1 cycle after the 5th data bit of 0x1C -> all outputs 0 and no pulses. The next complete 0x5A frame yields code_out=0x5A and history=16'h005A.

Source files
------------

// File: rtl/ps2_scancode_history.sv
// PS/2 receiver with E0/F0 prefix decode, DEPTH-byte history and hex display; byte pulses 1 clk after stop-bit event, no backpressure.
// Optional PS2_BREAK_FILTER_EN: history records only key presses instead of every accepted byte.
module hex_decoder (
   input  logic [3:0] hex,
   output logic [6:0] seg
);
   // Active-low segments, bit order {g,f,e,d,c,b,a}
   always_comb begin
      seg = 7'b1111111;
      case (hex)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
   end
endmodule

module ps2_scancode_history #(
   parameter int DEPTH          = 2,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 ps2_clock,
   input  logic                 ps2_data,
   output logic [7:0]           code_out,
   output logic                 code_valid,
   output logic                 key_valid,
   output logic                 code_ext,
   output logic                 code_break,
   output logic                 frame_error,
   output logic [8*DEPTH-1:0]   history,
   output logic [14*DEPTH-1:0]  segments
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t             state;
   logic               clk_s1, clk_s2, clk_prev;
   logic               dat_s1, dat_s2;
   logic [2:0]         bit_cnt;
   logic [7:0]         shift_dat;
   logic               parity_bit;
   logic [CW-1:0]      to_cnt;
   logic               ext_pend, brk_pend;
   logic               bit_evt, frame_ok, accept, is_prefix, push;
   logic [8*DEPTH-1:0] hist_next;

   always_comb begin
      bit_evt   = clk_prev & ~clk_s2;
      frame_ok  = dat_s2 & (^{shift_dat, parity_bit});
      accept    = (state == STOP) && bit_evt && frame_ok;
      is_prefix = (shift_dat == 8'hE0) || (shift_dat == 8'hF0);
`ifdef PS2_BREAK_FILTER_EN
      push      = accept && !is_prefix && !brk_pend;
`else
      push      = accept;
`endif
      // Shift-then-overwrite keeps DEPTH=1 legal without a negative slice
      hist_next      = history << 8;
      hist_next[7:0] = shift_dat;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         clk_s1      <= 1'b1;
         clk_s2      <= 1'b1;
         clk_prev    <= 1'b1;
         dat_s1      <= 1'b1;
         dat_s2      <= 1'b1;
         bit_cnt     <= '0;
         shift_dat   <= '0;
         parity_bit  <= 1'b0;
         to_cnt      <= '0;
         ext_pend    <= 1'b0;
         brk_pend    <= 1'b0;
         code_out    <= '0;
         code_valid  <= 1'b0;
         key_valid   <= 1'b0;
         code_ext    <= 1'b0;
         code_break  <= 1'b0;
         frame_error <= 1'b0;
         history     <= '0;
      end else begin
         clk_s1      <= ps2_clock;
         clk_s2      <= clk_s1;
         clk_prev    <= clk_s2;
         dat_s1      <= ps2_data;
         dat_s2      <= dat_s1;
         code_valid  <= 1'b0;
         key_valid   <= 1'b0;
         frame_error <= 1'b0;

         if (bit_evt) begin
            to_cnt <= '0;
            case (state)
               IDLE: if (!dat_s2) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
               DATA: begin
                  shift_dat <= {dat_s2, shift_dat[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  parity_bit <= dat_s2;
                  state      <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (frame_ok) begin
                     code_out   <= shift_dat;
                     code_valid <= 1'b1;
                     if (shift_dat == 8'hE0) ext_pend <= 1'b1;
                     else if (shift_dat == 8'hF0) brk_pend <= 1'b1;
                     else begin
                        key_valid  <= 1'b1;
                        code_ext   <= ext_pend;
                        code_break <= brk_pend;
                        ext_pend   <= 1'b0;
                        brk_pend   <= 1'b0;
                     end
                  end else begin
                     frame_error <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            if (to_cnt == TO_LAST) begin
               state       <= IDLE;
               frame_error <= 1'b1;
               to_cnt      <= '0;
            end else begin
               to_cnt <= to_cnt + CW'(1);
            end
         end else begin
            to_cnt <= '0;
         end

         if (push) history <= hist_next;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_digit
      hex_decoder u_lo (.hex(history[8*i +: 4]),     .seg(segments[14*i +: 7]));
      hex_decoder u_hi (.hex(history[8*i + 4 +: 4]), .seg(segments[14*i + 7 +: 7]));
   end
endmodule

// File: tb/tb_ps2_scancode_history.sv
// Randomized PS/2 frame bench for ps2_scancode_history against a byte-level reference model.
module tb_ps2_scancode_history;
   localparam int DEPTH = 2;
   localparam int TO    = 200;
   localparam int HALF  = 8;

   logic clk = 1'b0, reset = 1'b1, ps2_clock = 1'b1, ps2_data = 1'b1;
   logic [7:0] code_out;
   logic code_valid, key_valid, code_ext, code_break, frame_error;
   logic [8*DEPTH-1:0] history;
   logic [14*DEPTH-1:0] segments;

   ps2_scancode_history #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clk), .reset(reset), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
      .code_out(code_out), .code_valid(code_valid), .key_valid(key_valid),
      .code_ext(code_ext), .code_break(code_break), .frame_error(frame_error),
      .history(history), .segments(segments));

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;
   int n_cv = 0, n_kv = 0, n_fe = 0;

   always @(negedge clk) begin
      if (code_valid)  n_cv++;
      if (key_valid)   n_kv++;
      if (frame_error) n_fe++;
   end

   // Reference model state
   logic [8*DEPTH-1:0] m_hist;
   logic [7:0] m_code;
   logic m_ext_pend, m_brk_pend, m_ext, m_brk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      return t[n];
   endfunction

   function automatic logic [14*DEPTH-1:0] exp_segs(input logic [8*DEPTH-1:0] h);
      logic [14*DEPTH-1:0] s;
      s = '0;
      for (int i = 0; i < 2*DEPTH; i++) s[7*i +: 7] = seg7(h[4*i +: 4]);
      return s;
   endfunction

   task automatic model_reset();
      m_hist = '0; m_code = '0;
      m_ext_pend = 0; m_brk_pend = 0; m_ext = 0; m_brk = 0;
   endtask

   task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit stop, input int nbits);
      logic [10:0] fr;
      fr = {stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         repeat (HALF) @(negedge clk);
         ps2_clock = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2_clock = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      ps2_data = 1'b1;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".code"}, 32'(code_out), 32'(m_code));
      chk({tag, ".ext"},  32'(code_ext), 32'(m_ext));
      chk({tag, ".brk"},  32'(code_break), 32'(m_brk));
      chk({tag, ".hist"}, 32'(history), 32'(m_hist));
      chk({tag, ".seg"},  32'(segments), 32'(exp_segs(m_hist)));
   endtask

   task automatic apply_frame(input string tag, input logic [7:0] b, input bit bad_par, input bit stop);
      int cv0, kv0, fe0, ecv, ekv, efe;
      bit is_key, rec;
      cv0 = n_cv; kv0 = n_kv; fe0 = n_fe;
      send_bits(b, bad_par, stop, 11);
      repeat (4) @(negedge clk);
      ecv = 0; ekv = 0; efe = 0;
      if (!bad_par && stop) begin
         ecv = 1;
         m_code = b;
         is_key = (b != 8'hE0) && (b != 8'hF0);
`ifdef PS2_BREAK_FILTER_EN
         rec = is_key && !m_brk_pend;
`else
         rec = 1'b1;
`endif
         if (rec) m_hist = (m_hist << 8) | (8*DEPTH)'(b);
         if (b == 8'hE0) m_ext_pend = 1;
         else if (b == 8'hF0) m_brk_pend = 1;
         else begin
            ekv = 1; m_ext = m_ext_pend; m_brk = m_brk_pend;
            m_ext_pend = 0; m_brk_pend = 0;
         end
      end else begin
         efe = 1;
      end
      chk({tag, ".cv"}, 32'(n_cv - cv0), 32'(ecv));
      chk({tag, ".kv"}, 32'(n_kv - kv0), 32'(ekv));
      chk({tag, ".fe"}, 32'(n_fe - fe0), 32'(efe));
      check_outputs(tag);
   endtask

   initial begin
      int cv0, fe0, r;
      logic [7:0] b;
      bit bp, sb;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst.cv", 32'(code_valid), 0);
      chk("rst.kv", 32'(key_valid), 0);
      chk("rst.fe", 32'(frame_error), 0);
      check_outputs("rst");

      apply_frame("k1C", 8'h1C, 0, 1);
      apply_frame("bF0", 8'hF0, 0, 1);
      apply_frame("b1C", 8'h1C, 0, 1);
      apply_frame("eE0", 8'hE0, 0, 1);
      apply_frame("e75", 8'h75, 0, 1);
      apply_frame("p29", 8'h29, 0, 1);
      apply_frame("badpar", 8'h1C, 1, 1);
      apply_frame("badstop", 8'h1C, 0, 0);

      // Partial frame then silence past the timeout
      cv0 = n_cv; fe0 = n_fe;
      send_bits(8'h1C, 0, 1, 5);
      repeat (TO + 30) @(negedge clk);
      chk("to.fe", 32'(n_fe - fe0), 1);
      chk("to.cv", 32'(n_cv - cv0), 0);
      check_outputs("to");
      apply_frame("to29", 8'h29, 0, 1);

      // Reset after start + 5 data bits
      cv0 = n_cv; fe0 = n_fe;
      send_bits(8'h1C, 0, 1, 6);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      chk("mrst.cv", 32'(code_valid), 0);
      chk("mrst.fe", 32'(frame_error), 0);
      check_outputs("mrst");
      repeat (TO + 30) @(negedge clk);
      chk("mrst.nocv", 32'(n_cv - cv0), 0);
      chk("mrst.nofe", 32'(n_fe - fe0), 0);
      apply_frame("r5A", 8'h5A, 0, 1);

      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 5);
         b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
         r = $urandom_range(0, 15);
         bp = (r == 0);
         sb = (r != 1);
         apply_frame("rnd", b, bp, sb);
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
